// File: rtl/bit_reverse_buffer_pkg.sv
// Shared FFT definitions: default sizes, log2 and bit-reversal helpers, read FSM states.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package bit_reverse_buffer_pkg;

    localparam int DEFAULT_N     = 64;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Ceiling log2, usable in constant expressions for parameter-derived widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Reverse the low 'bits' bits of value; higher result bits are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
        logic [31:0] result;
        int          src;
        result = '0;
        for (int i = 0; i < bits; i++) begin
            src = bits - 1 - i;
            result[i[4:0]] = value[src[4:0]];
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_reverse_buffer_reorder_ram.sv
// Reorder storage: simple dual-port RAM, one write port, one registered read port.
// Latency: read data valid one cycle after rd_en; write is visible on the following cycle.
// Backpressure: none; both ports accept an access every cycle.
module bit_reverse_buffer_reorder_ram
    import bit_reverse_buffer_pkg::*;
#(
    parameter  int DEPTH = 2 * DEFAULT_N,
    parameter  int DW    = 2 * DEFAULT_WIDTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    // No reset on the array so it maps onto block RAM.
    logic [DW-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/bit_reverse_buffer.sv
// Reorders bit-reversed FFT output frames into natural order using two ping-pong banks.
// Latency: N+1 cycles for a contiguous frame; first output 2 cycles after the last input.
// Backpressure: none; input may gap freely, each frame is emitted as N back-to-back samples.
module bit_reverse_buffer
    import bit_reverse_buffer_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             idata_en,
    input  logic [WIDTH-1:0] idata_r,
    input  logic [WIDTH-1:0] idata_i,
    output logic             odata_en,
    output logic [WIDTH-1:0] odata_r,
    output logic [WIDTH-1:0] odata_i
);

    localparam int               LOG_N = clog2(N);
    localparam logic [LOG_N-1:0] LAST  = LOG_N'(N - 1);
    localparam logic [LOG_N-1:0] ONE   = LOG_N'(1);

    logic [LOG_N-1:0]   wr_count;
    logic               wr_bank;
    logic               wr_en;
    logic [LOG_N:0]     wr_addr;
    logic               rd_start;

    rd_state_t          state;
    logic [LOG_N-1:0]   rd_count;
    logic               rd_bank;
    logic               rd_en;
    logic [LOG_N:0]     rd_addr;
    logic [2*WIDTH-1:0] rd_data;

    // A sample presented while reset is high must not land in the RAM or start a read.
    assign wr_en    = idata_en && !reset;
    assign rd_start = wr_en && (wr_count == LAST);
    assign wr_addr  = {wr_bank, LOG_N'(bitrev(32'(wr_count), LOG_N))};

    // Write side: count accepted samples, flip banks at the end of each frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count <= '0;
            wr_bank  <= 1'b0;
        end else if (idata_en) begin
            wr_count <= wr_count + ONE;
            if (wr_count == LAST) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read FSM: state/rd_count name the sample the RAM is presenting this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RD_IDLE;
            rd_count <= '0;
            rd_bank  <= 1'b0;
        end else if (rd_start) begin
            state    <= RD_READ;
            rd_count <= '0;
            rd_bank  <= wr_bank;
        end else if (state == RD_READ) begin
            if (rd_count == LAST) begin
                state    <= RD_IDLE;
                rd_count <= '0;
            end else begin
                rd_count <= rd_count + ONE;
            end
        end
    end

    // Read address runs one step ahead of the FSM to hide the RAM read register;
    // on rd_start the bank still indexed by wr_bank is the one just completed.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = {rd_bank, rd_count + ONE};
        if (rd_start) begin
            rd_en   = 1'b1;
            rd_addr = {wr_bank, {LOG_N{1'b0}}};
        end else if ((state == RD_READ) && (rd_count != LAST)) begin
            rd_en = 1'b1;
        end
    end

    bit_reverse_buffer_reorder_ram #(
        .DEPTH (2 * N),
        .DW    (2 * WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({idata_r, idata_i}),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Output register: capture RAM data while reading, hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            odata_en <= 1'b0;
            odata_r  <= '0;
            odata_i  <= '0;
        end else begin
            odata_en <= (state == RD_READ);
            if (state == RD_READ) begin
                {odata_r, odata_i} <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_bit_reverse_buffer.sv
// Bench for bit_reverse_buffer at N=64, 16 and 4 with a cycle-exact output scoreboard.
// Latency: expected output cycles derive from the cycle of the last accepted input.
// Backpressure: not applicable; stimulus includes gaps and resets.
module tb_bit_reverse_buffer;

    localparam int NS [3] = '{64, 16, 4};

    typedef struct {
        int          dut;
        int          cyc;
        logic [15:0] r;
        logic [15:0] i;
    } exp_t;

    typedef struct {
        int          dut;
        int          n;
        logic [15:0] r;
        logic [15:0] i;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        idata_en_a [3];
    logic [15:0] idata_r_a  [3];
    logic [15:0] idata_i_a  [3];
    logic        odata_en_a [3];
    logic [15:0] odata_r_a  [3];
    logic [15:0] odata_i_a  [3];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sbq [$];
    logic [15:0] cap_r [3][64];
    logic [15:0] cap_i [3][64];
    int          out_pos [3] = '{0, 0, 0};
    vec_t        vtab [13];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bit_reverse_buffer #(
            .N     (NS[g]),
            .WIDTH (16)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .idata_en (idata_en_a[g]),
            .idata_r  (idata_r_a[g]),
            .idata_i  (idata_i_a[g]),
            .odata_en (odata_en_a[g]),
            .odata_r  (odata_r_a[g]),
            .odata_i  (odata_i_a[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lg2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    function automatic logic [15:0] samp_r(input int pat, input int f, input int j);
        if (pat == 0) return 16'(256 * f + j);
        if (j % 2 == 1) return 16'(32'h8000 + j / 2);
        return 16'(32'h7FFF - j / 2);
    endfunction

    function automatic logic [15:0] samp_i(input int pat, input int f, input int j);
        if (pat == 0) return 16'(-j - 17 * f);
        return ~samp_r(pat, f, j);
    endfunction

    // Scoreboard monitor: every valid output pops one expectation (dut, cycle, data).
    always @(negedge clock) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (odata_en_a[k] === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out dut=%0d actual odata_en=1 required 0 (cycle %0d)", k, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("out_dut", k, e.dut);
                    check("out_cycle", cyc, e.cyc);
                    check("out_r", 32'(odata_r_a[k]), 32'(e.r));
                    check("out_i", 32'(odata_i_a[k]), 32'(e.i));
                end
                cap_r[k][out_pos[k]] = odata_r_a[k];
                cap_i[k][out_pos[k]] = odata_i_a[k];
                out_pos[k] = (out_pos[k] + 1) % NS[k];
            end else begin
                out_pos[k] = 0;
            end
        end
    end

    // Drive one frame on DUT k with up to two gaps; push npush expected outputs.
    task automatic send_frame(input int k, input int f, input int pat,
                              input int ga, input int gla, input int gb, input int glb,
                              input int npush, output int last_cyc);
        int n  = NS[k];
        int lg = lg2(NS[k]);
        exp_t e;
        last_cyc = 0;
        for (int j = 0; j < n; j++) begin
            @(posedge clock); #1;
            idata_en_a[k] = 1'b1;
            idata_r_a[k]  = samp_r(pat, f, j);
            idata_i_a[k]  = samp_i(pat, f, j);
            if (j == n - 1) last_cyc = cyc;
            if (j == ga || j == gb) begin
                repeat ((j == ga) ? gla : glb) begin
                    @(posedge clock); #1;
                    idata_en_a[k] = 1'b0;
                    idata_r_a[k]  = 16'hDEAD;
                    idata_i_a[k]  = 16'hBEEF;
                end
            end
        end
        for (int m = 0; m < npush; m++) begin
            e.dut = k;
            e.cyc = last_cyc + 2 + m;
            e.r   = samp_r(pat, f, brev(m, lg));
            e.i   = samp_i(pat, f, brev(m, lg));
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int k, input int ncyc);
        repeat (ncyc) begin
            @(posedge clock); #1;
            idata_en_a[k] = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (sbq.size() != 0 && c < budget) begin
            @(posedge clock); #1;
            c++;
        end
        check("drain_pending", sbq.size(), 0);
        sbq.delete();
        repeat (4) begin @(posedge clock); #1; end
    endtask

    task automatic table_check(input int k);
        for (int t = 0; t < 13; t++) begin
            if (vtab[t].dut == k) begin
                check($sformatf("tab_r d%0d n%0d", k, vtab[t].n), 32'(cap_r[k][vtab[t].n]), 32'(vtab[t].r));
                check($sformatf("tab_i d%0d n%0d", k, vtab[t].n), 32'(cap_i[k][vtab[t].n]), 32'(vtab[t].i));
            end
        end
    endtask

    task automatic check_cleared(input int k, input string tag);
        check({tag, "_en"}, 32'(odata_en_a[k]), 0);
        check({tag, "_r"},  32'(odata_r_a[k]),  0);
        check({tag, "_i"},  32'(odata_i_a[k]),  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lc;
        vtab[0]  = '{0, 0,  16'h0000, 16'h0000};
        vtab[1]  = '{0, 1,  16'h0020, 16'hFFE0};
        vtab[2]  = '{0, 2,  16'h0010, 16'hFFF0};
        vtab[3]  = '{0, 3,  16'h0030, 16'hFFD0};
        vtab[4]  = '{0, 63, 16'h003F, 16'hFFC1};
        vtab[5]  = '{1, 1,  16'h7FFB, 16'h8004};
        vtab[6]  = '{1, 5,  16'h7FFA, 16'h8005};
        vtab[7]  = '{1, 8,  16'h8000, 16'h7FFF};
        vtab[8]  = '{1, 15, 16'h8007, 16'h7FF8};
        vtab[9]  = '{2, 0,  16'h7FFF, 16'h8000};
        vtab[10] = '{2, 1,  16'h7FFE, 16'h8001};
        vtab[11] = '{2, 2,  16'h8000, 16'h7FFF};
        vtab[12] = '{2, 3,  16'h8001, 16'h7FFE};

        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            idata_en_a[k] = 1'b0;
            idata_r_a[k]  = '0;
            idata_i_a[k]  = '0;
        end
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) check_cleared(k, "reset_state");

        // Single contiguous frame, N=64.
        send_frame(0, 0, 0, -1, 0, -1, 0, 64, lc);
        idle(0, 1);
        drain(300);
        table_check(0);

        // Three back-to-back frames: output must stay continuous.
        for (int f = 0; f < 3; f++) send_frame(0, f, 0, -1, 0, -1, 0, 64, lc);
        idle(0, 1);
        drain(400);

        // Gapped frame: pause after samples 10 and 40.
        send_frame(0, 0, 0, 10, 5, 40, 3, 64, lc);
        idle(0, 1);
        drain(300);
        table_check(0);

        // Partial frame of 30 samples, then a one-cycle reset with a sample offered.
        for (int j = 0; j < 30; j++) begin
            @(posedge clock); #1;
            idata_en_a[0] = 1'b1;
            idata_r_a[0]  = samp_r(0, 7, j);
            idata_i_a[0]  = samp_i(0, 7, j);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        idata_r_a[0] = 16'h5555;
        idata_i_a[0] = 16'hAAAA;
        @(posedge clock); #1;
        reset = 1'b0;
        idata_en_a[0] = 1'b0;
        check_cleared(0, "partial_rst");
        idle(0, 2);
        send_frame(0, 3, 0, -1, 0, -1, 0, 64, lc);
        idle(0, 1);
        drain(300);

        // Reset while output n=20 is on the bus; odata_en must drop next cycle.
        send_frame(0, 4, 0, -1, 0, -1, 0, 21, lc);
        idle(0, 1);
        repeat (21) begin @(posedge clock); #1; end
        check("midread_cycle", cyc, lc + 22);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_cleared(0, "midread_rst");
        idle(0, 3);
        check("midread_queue", sbq.size(), 0);
        send_frame(0, 5, 0, -1, 0, -1, 0, 64, lc);
        idle(0, 1);
        drain(300);

        // N=16 with extreme values, then back-to-back frames.
        send_frame(1, 0, 1, -1, 0, -1, 0, 16, lc);
        idle(1, 1);
        drain(100);
        table_check(1);
        send_frame(1, 1, 0, -1, 0, -1, 0, 16, lc);
        send_frame(1, 2, 1, -1, 0, -1, 0, 16, lc);
        idle(1, 1);
        drain(100);

        // N=4 with extreme values, then back-to-back frames.
        send_frame(2, 0, 1, -1, 0, -1, 0, 4, lc);
        idle(2, 1);
        drain(50);
        table_check(2);
        send_frame(2, 1, 0, -1, 0, -1, 0, 4, lc);
        send_frame(2, 2, 1, -1, 0, -1, 0, 4, lc);
        idle(2, 1);
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
